alu_sequencer: RTL and testbench

- Fetch/decode/execute control unit for the 8-bit add/subtract ALU (the `A_in`/`B_in`/`SUB`/`OE` datapath).
- Reads instructions and operands from a 16-byte memory through a req/ack read port.
- Owns the accumulator, the B operand register, the program counter and the carry flag.
- Drives the ALU's operand and control inputs and captures the ALU's result.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/alu_sequencer_mem_read_port.sv | 32 +++
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared opcode and state definitions for the ALU sequencer.
package seq_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_READ_OP = 3'd3,
        S_EXEC    = 3'd4,
        S_HALT    = 3'd5
    } state_e;

endpackage

// File: rtl/alu_sequencer_mem_read_port.sv
// Memory read port: holds request and address until ack, then forces one idle
// cycle so back-to-back reads are always separated.
module mem_read_port #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              ack_i,
    output logic              rd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              accept_o,
    output logic              gap_o
);

    logic gap_q;

    assign rd_o     = req_i & ~gap_q;
    assign addr_o   = addr_i;
    assign accept_o = rd_o & ack_i;
    assign gap_o    = gap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= accept_o;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control for an external 8-bit add/subtract ALU.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int START_PC = 0
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_sub,
    output logic              alu_oe,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              carry,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                carry_q, carry_d;
    logic                outv_q, outv_d;

    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_accept;
    logic                rd_gap;
    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   operand;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    assign rd_req  = (state_q == S_FETCH) || (state_q == S_READ_OP);
    assign rd_addr = (state_q == S_FETCH) ? pc_q : operand;

    mem_read_port #(.ADDR_W(ADDR_W)) u_rd_port (
        .clk_i    (CLK),
        .rst_ni   (RST_n),
        .req_i    (rd_req),
        .addr_i   (rd_addr),
        .ack_i    (mem_ack),
        .rd_o     (mem_rd),
        .addr_o   (mem_addr),
        .accept_o (rd_accept),
        .gap_o    (rd_gap)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        b_d     = b_q;
        ir_d    = ir_q;
        out_d   = out_q;
        carry_d = carry_q;
        outv_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (rd_accept) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: state_d = S_READ_OP;
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = S_FETCH;
                    end
                    OP_OUT: begin
                        out_d   = acc_q;
                        outv_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_READ_OP: begin
                // Operand is captured on ack; the state advances in the idle cycle after it.
                if (rd_accept) begin
                    if (opcode == OP_LDA) acc_d = mem_data;
                    else                  b_d   = mem_data;
                end
                if (rd_gap) state_d = (opcode == OP_LDA) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                acc_d   = alu_result;
                carry_d = alu_cout;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(START_PC);
            acc_q   <= '0;
            b_q     <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            outv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            outv_q  <= outv_d;
        end
    end

    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_oe    = (state_q == S_EXEC);
    assign alu_sub   = (state_q == S_EXEC) && (opcode == OP_SUB);
    assign out_port  = out_q;
    assign out_valid = outv_q;
    assign carry     = carry_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference model, memory responder
// with wait states, and a behavioural add/subtract ALU.
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'hA5;
    logic [7:0] alu_a, alu_b, alu_result, out_port;
    logic       alu_sub, alu_oe, alu_cout, out_valid, carry, halted;

    always #5 CLK = ~CLK;

    alu_sequencer #(.ADDR_W(4), .DATA_W(8), .START_PC(0)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sub    (alu_sub),
        .alu_oe     (alu_oe),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .carry      (carry),
        .halted     (halted)
    );

    // External ALU: A + B, or A + ~B + 1 when subtracting; result only driven while enabled.
    logic [8:0] alu_sum;
    assign alu_sum    = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1)
                                : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_result = alu_oe ? alu_sum[7:0] : 8'h00;
    assign alu_cout   = alu_oe & alu_sum[8];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] mem [16];
    int         waits = 0;
    bit         force_ack = 1'b0;

    // Memory responder: answers after `waits` idle request cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (force_ack) begin
                mem_ack  = 1'b1;
                mem_data = 8'h3C;
            end else if (mem_rd) begin
                if (wcnt >= waits) begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    wcnt     = 0;
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = 8'hA5;
                    wcnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                mem_data = 8'hA5;
                wcnt     = 0;
            end
        end
    end

    logic [7:0] exp_out[$];
    logic [3:0] exp_rd[$];
    logic [7:0] exp_ea[$];
    logic [7:0] exp_eb[$];
    logic       exp_sub[$];
    logic [7:0] m_a;
    logic       m_c;
    int         m_cycles, m_execs;

    // Instruction-level interpreter of the program in mem.
    task automatic model_run(input int max_outs);
        int pc, t, outs;
        logic [7:0] a, ins, v;
        logic [3:0] opnd;
        logic c;
        pc = 0; a = 8'h00; c = 1'b0; outs = 0;
        exp_out.delete(); exp_rd.delete(); exp_ea.delete(); exp_eb.delete(); exp_sub.delete();
        m_cycles = 0; m_execs = 0;
        for (int step = 0; step < 4000; step++) begin
            ins = mem[pc];
            exp_rd.push_back(4'(pc));
            pc = (pc + 1) % 16;
            opnd = ins[3:0];
            v = mem[opnd];
            m_cycles += 2 + waits;
            if (ins[7:4] == 4'h0) begin
                exp_rd.push_back(opnd);
                a = v;
                m_cycles += 2 + waits;
            end else if (ins[7:4] == 4'h1 || ins[7:4] == 4'h2) begin
                exp_rd.push_back(opnd);
                exp_ea.push_back(a);
                exp_eb.push_back(v);
                m_execs++;
                m_cycles += 3 + waits;
                if (ins[7:4] == 4'h1) begin
                    t = int'(a) + int'(v);
                    c = (t > 255);
                    a = 8'(t % 256);
                    exp_sub.push_back(1'b0);
                end else begin
                    c = (a >= v);
                    a = 8'((int'(a) - int'(v) + 256) % 256);
                    exp_sub.push_back(1'b1);
                end
            end else if (ins[7:4] == 4'h3) begin
                pc = int'(opnd);
            end else if (ins[7:4] == 4'hE) begin
                exp_out.push_back(a);
                outs++;
                if (outs >= max_outs) break;
            end else if (ins[7:4] == 4'hF) begin
                break;
            end
        end
        m_a = a;
        m_c = c;
    endtask

    bit         mon_en = 1'b0;
    bit         counting = 1'b0;
    bit         strict_rd = 1'b0;
    int         n_outs, n_execs, run_cycles;
    logic [7:0] last_out, out256;
    logic       prev_rd = 1'b0, prev_acc = 1'b0, prev_oe = 1'b0;
    logic [3:0] prev_addr = 4'h0;

    // Per-cycle comparison of the DUT against the model's expectations.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (mon_en && RST_n) begin
            if (counting && !halted) run_cycles++;
            if (out_valid) begin
                n_outs++;
                last_out = out_port;
                if (n_outs == 256) out256 = out_port;
                if (exp_out.size() == 0) chk("out_extra", 1, 0);
                else begin
                    e = exp_out.pop_front();
                    chk("out_port", out_port, e);
                end
            end
            if (alu_oe) begin
                n_execs++;
                chk("oe_one_cycle", prev_oe, 0);
                if (exp_sub.size() == 0) chk("exec_extra", 1, 0);
                else begin
                    chk("exec_sub", alu_sub, exp_sub.pop_front());
                    chk("exec_a", alu_a, exp_ea.pop_front());
                    chk("exec_b", alu_b, exp_eb.pop_front());
                end
            end else begin
                chk("sub_idle", alu_sub, 0);
            end
            if (prev_acc) chk("rd_gap", mem_rd, 0);
            else if (prev_rd && mem_rd) chk("addr_stable", mem_addr, prev_addr);
            if (mem_rd && mem_ack) begin
                if (exp_rd.size() > 0) chk("rd_addr", mem_addr, exp_rd.pop_front());
                else if (strict_rd) chk("rd_extra", 1, 0);
            end
        end
        prev_acc  = mem_rd & mem_ack;
        prev_rd   = mem_rd;
        prev_addr = mem_addr;
        prev_oe   = alu_oe;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        counting = 1'b0;
        run = 1'b0;
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_oe", alu_oe, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_carry", carry, 0);
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic run_prog(input bit do_rst, input int max_outs, input bit expect_halt);
        bit done;
        if (do_rst) do_reset();
        model_run(max_outs);
        n_outs = 0; n_execs = 0; run_cycles = 0;
        strict_rd = expect_halt;
        mon_en = 1'b1;
        @(negedge CLK);
        run = 1'b1;
        @(posedge CLK);
        #1 run = 1'b0;
        counting = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLK);
            #1;
            if (expect_halt ? halted : (n_outs >= max_outs)) begin
                done = 1'b1;
                break;
            end
        end
        chk("finished", done, 1);
        chk("outs_left", exp_out.size(), 0);
        if (expect_halt) begin
            chk("exec_count", n_execs, m_execs);
            chk("cycles", run_cycles, m_cycles);
            chk("reads_left", exp_rd.size(), 0);
            chk("final_a", alu_a, m_a);
            chk("final_carry", carry, m_c);
        end
        mon_en = 1'b0;
        counting = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h2B; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[9] = 8'h05; mem[10] = 8'h03; mem[11] = 8'h02;
    endtask

    initial begin
        bit found;

        // Basic program, zero-wait memory.
        load_basic();
        waits = 0;
        run_prog(1'b1, 100, 1'b1);
        chk("basic_out", last_out, 8'h06);
        chk("basic_nout", n_outs, 1);
        chk("basic_carry", carry, 1);
        chk("basic_cycles", run_cycles, 18);
        chk("basic_halted", halted, 1);

        // Wraparound carry.
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[9] = 8'hFF; mem[10] = 8'h01;
        run_prog(1'b1, 100, 1'b1);
        chk("wrap_out", last_out, 8'h00);
        chk("wrap_carry", carry, 1);
        chk("wrap_execs", n_execs, 1);
        chk("wrap_cycles", run_cycles, 13);

        // Wait states: 3 idle cycles per read, 8 reads.
        load_basic();
        waits = 3;
        run_prog(1'b1, 100, 1'b1);
        chk("wait_out", last_out, 8'h06);
        chk("wait_cycles", run_cycles, 42);
        waits = 0;

        // Undefined opcodes behave as NOP.
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h50; mem[2] = 8'h70; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[9] = 8'h42;
        run_prog(1'b1, 100, 1'b1);
        chk("nop_out", last_out, 8'h42);
        chk("nop_execs", n_execs, 0);
        chk("nop_cycles", run_cycles, 12);

        // JMP loop counting past 0xFF.
        clear_mem();
        mem[0] = 8'h1F; mem[1] = 8'hE0; mem[2] = 8'h30; mem[15] = 8'h01;
        run_prog(1'b1, 257, 1'b0);
        chk("loop_out256", out256, 8'h00);
        chk("loop_last", last_out, 8'h01);

        // Reset during the operand read of a running loop.
        run_prog(1'b1, 3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (mem_rd && mem_addr == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_found_readop", found, 1);
        chk("pre_rst_a", alu_a, 8'h03);
        #2 RST_n = 1'b0;
        #1;
        chk("async_mem_rd", mem_rd, 0);
        chk("async_alu_oe", alu_oe, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_halted", halted, 0);
        chk("async_alu_a", alu_a, 0);
        chk("async_alu_b", alu_b, 0);
        chk("async_out_port", out_port, 0);
        chk("async_carry", carry, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_mem_rd", mem_rd, 0);
            chk("idle_halted", halted, 0);
        end
        force_ack = 1'b0;
        @(negedge CLK);

        // Restart without another reset: PC must begin at START_PC.
        load_basic();
        run_prog(1'b0, 100, 1'b1);
        chk("restart_out", last_out, 8'h06);
        chk("restart_cycles", run_cycles, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
